// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the serial packed-BCD adder controller.
package bcd_serial_add_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    localparam logic [4:0] BCD_MAX  = 5'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    // Width of the digit index; a single-digit adder still gets one bit.
    function automatic int idx_width(input int digits);
        return (digits <= 2) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_cell.sv
// Combinational single-digit BCD adder: x + y + c with decimal correction.
// Digits above 9 go through the same rule unchanged (no saturation).
module bcd_digit_cell
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c,
    output logic [3:0] digit,
    output logic       carry
);

    logic [4:0] t;

    // Binary sum, then add 6 (mod 16) whenever the sum passes 9.
    always_comb begin
        t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        if (t > BCD_MAX) begin
            digit = t[3:0] + BCD_CORR;
            carry = 1'b1;
        end else begin
            digit = t[3:0];
            carry = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller: one digit per clock, LSD first,
// through a single shared digit cell.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; sum/cout/err hold the last result
// ST_ADD  | processing digit idx; leaves after digit DIGITS-1 with done
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IDXW = idx_width(DIGITS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      a_dig   [DIGITS];
    logic [3:0]      b_dig   [DIGITS];
    logic [3:0]      sum_dig [DIGITS];
    logic [IDXW-1:0] idx;
    logic            carry;
    logic            accept;
    logic            last;
    logic            in_err;
    logic [3:0]      cell_digit;
    logic            cell_carry;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (state == ST_ADD) && (idx == LAST_IDX);
    assign busy   = (state == ST_ADD);

    bcd_digit_cell u_cell (
        .x     (a_dig[idx]),
        .y     (b_dig[idx]),
        .c     (carry),
        .digit (cell_digit),
        .carry (cell_carry)
    );

    // Flag any non-BCD nibble on the live operand inputs; latched at accept.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (({1'b0, a[4*i +: 4]} > BCD_MAX) || ({1'b0, b[4*i +: 4]} > BCD_MAX))
                in_err = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_ADD;
            ST_ADD:  if (last)   state_nxt = ST_IDLE;
            default:             state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, digit sequencing, carry ripple and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                a_dig[i]   <= 4'd0;
                b_dig[i]   <= 4'd0;
                sum_dig[i] <= 4'd0;
            end
            idx   <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                for (int i = 0; i < DIGITS; i++) begin
                    a_dig[i]   <= a[4*i +: 4];
                    b_dig[i]   <= b[4*i +: 4];
                    sum_dig[i] <= 4'd0;
                end
                idx   <= '0;
                carry <= cin;
                cout  <= 1'b0;
                err   <= in_err;
            end else if (state == ST_ADD) begin
                sum_dig[idx] <= cell_digit;
                carry        <= cell_carry;
                if (last) begin
                    cout <= cell_carry;
                    done <= 1'b1;
                end else begin
                    idx <= idx + IDXW'(1);
                end
            end
        end
    end

    // Pack the digit registers onto the sum port.
    always_comb begin
        sum = '0;
        for (int i = 0; i < DIGITS; i++)
            sum[4*i +: 4] = sum_dig[i];
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=4).
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: decimal arithmetic for valid BCD, digit rule for non-BCD input.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t   e;
        longint va, vb, tot, p;
        int     c, t;
        e = '0;
        for (int i = 0; i < DIGITS; i++)
            if (ta[4*i +: 4] > 9 || tb[4*i +: 4] > 9) e.err = 1'b1;
        if (!e.err) begin
            va = 0; vb = 0; p = 1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                va = va * 10 + ta[4*i +: 4];
                vb = vb * 10 + tb[4*i +: 4];
                p  = p * 10;
            end
            tot    = va + vb + tc;
            e.cout = (tot >= p);
            tot    = tot % p;
            for (int i = 0; i < DIGITS; i++) begin
                e.sum[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = tc;
            for (int i = 0; i < DIGITS; i++) begin
                t = ta[4*i +: 4] + tb[4*i +: 4] + c;
                if (t > 9) begin
                    e.sum[4*i +: 4] = 4'(t + 6);
                    c = 1;
                end else begin
                    e.sum[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            e.cout = c[0];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++)
            v[4*i +: 4] = (allow_bad && $urandom_range(0, 5) == 0)
                          ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Issue one operation (called just after a falling edge) and check its timing.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit glitch);
        exp_t e;
        e = model(ta, tb, tc);
        a = ta; b = tb; cin = tc; start = 1'b1;
        sb_q.push_back(e);
        for (int k = 1; k <= DIGITS + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                chk("err_after_start", err, e.err);
                chk("sum_cleared", sum, 0);
                chk("cout_cleared", cout, 0);
            end
            if (glitch && k == 2) begin
                start = 1'b1; a = ~ta; b = W'($urandom); cin = ~tc;
            end
            if (glitch && k == 3) start = 1'b0;
            if (k <= DIGITS) begin
                chk("busy_during_add", busy, 1);
                chk("done_early", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sum"},  sum,  0);
        chk({tag, "_cout"}, cout, 0);
        chk({tag, "_err"},  err,  0);
    endtask

    // Monitor: every done pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("done_without_request", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("result_sum",  sum,  e.sum);
                    chk("result_cout", cout, e.cout);
                    chk("result_err",  err,  e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        idle_cycle();

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0); idle_cycle();
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0); idle_cycle();
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0); idle_cycle();
        run_op(16'h00A0, 16'h0000, 1'b0, 1'b0); idle_cycle();
        run_op(16'h2468, 16'h1357, 1'b1, 1'b1); idle_cycle();

        // Abort in the second ADD cycle: outputs clear at once, no done follows.
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        chk_all_zero("abort_hold");
        rst = 1'b0;
        repeat (DIGITS + 2) idle_cycle();

        // Back-to-back: the next start lands in the done cycle.
        run_op(16'h4321, 16'h0789, 1'b1, 1'b0);
        run_op(16'h5555, 16'h4445, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            run_op(rand_operand(1'b1), rand_operand(1'b1), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        repeat (3) idle_cycle();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
